// File: rtl/or1200_vlx_wrseq.sv
// Byte write sequencer: a 4-entry byte FIFO feeding single-byte store requests,
// with an auto-incrementing address set through an SPR and an optional FF->00 stuffing pass.
// Optional feature macro: OR1200_VLX_STUFF_EN (defined: every 8'hFF is followed by an 8'h00 write).
// Ports:
//   clk_i, rst_i                  clock, async active-high reset
//   byte_valid_i, byte_i          byte offer from the packer
//   byte_ready_o                  FIFO has room (transfer on valid & ready)
//   flush_i                       one-cycle request to drain the FIFO under stall
//   spr_cs, spr_write, spr_dat_i  SPR load of the base address (idle only)
//   spr_dat_o                     current write address
//   wr_req_o, wr_addr_o, wr_dat_o byte-write request to the store unit
//   ack_i                         store unit completed the current write
//   stall_cpu_o                   hold CPU fetch
//   busy_o                        FIFO non-empty or a write in progress
module or1200_vlx_wrseq (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic        byte_ready_o,
  input  logic        flush_i,
  input  logic        spr_cs,
  input  logic        spr_write,
  input  logic [31:0] spr_dat_i,
  output logic [31:0] spr_dat_o,
  output logic        wr_req_o,
  output logic [31:0] wr_addr_o,
  output logic [31:0] wr_dat_o,
  input  logic        ack_i,
  output logic        stall_cpu_o,
  output logic        busy_o
);

  localparam logic [31:0] RST_ADDR = 32'h0383C240;

`ifdef OR1200_VLX_STUFF_EN
  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_STUFF
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE
  } state_t;
`endif

  state_t      state_q;
  logic        req_q;
  logic [7:0]  dat_q;
  logic [31:0] addr_q;
  logic        flush_q;
  logic        flush_d;

  logic [7:0]  fifo_q [4];
  logic [1:0]  wptr_q;
  logic [1:0]  rptr_q;
  logic [2:0]  cnt_q;
  logic [2:0]  cnt_d;

  logic        push;
  logic        pop;
  logic        ack_act;
  logic        stuff_go;
  logic        spr_we;
  logic [7:0]  head;

  assign byte_ready_o = (cnt_q < 3'd4);
  assign push         = byte_valid_i & byte_ready_o;
  assign head         = fifo_q[rptr_q];
  assign ack_act      = ack_i & (state_q != S_IDLE);
  assign spr_we       = spr_cs & spr_write;

`ifdef OR1200_VLX_STUFF_EN
  assign stuff_go = (state_q == S_WRITE) & (dat_q == 8'hFF);
`else
  assign stuff_go = 1'b0;
`endif

  // Pop uses the registered count, so a byte pushed into an empty
  // FIFO is never popped in the same cycle.
  assign pop = (cnt_q != 3'd0) &
               ((state_q == S_IDLE) | (ack_act & ~stuff_go));

  assign cnt_d = cnt_q + {2'b00, push} - {2'b00, pop};

  assign busy_o = (cnt_q != 3'd0) | (state_q != S_IDLE);

  // Pending is armed by a flush while there is (or is about to be)
  // work, and drops at the end of the first cycle busy_o is low.
  assign flush_d = (flush_i & (busy_o | push)) | (flush_q & busy_o);

  assign stall_cpu_o = (byte_valid_i & ~byte_ready_o) | flush_q;

  assign wr_req_o  = req_q;
  assign wr_addr_o = addr_q;
  assign wr_dat_o  = {24'h000000, dat_q};
  assign spr_dat_o = addr_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < 4; i++) begin
        fifo_q[i] <= 8'h00;
      end
      wptr_q <= 2'd0;
      rptr_q <= 2'd0;
      cnt_q  <= 3'd0;
    end else begin
      if (push) begin
        fifo_q[wptr_q] <= byte_i;
        wptr_q         <= wptr_q + 2'd1;
      end
      if (pop) begin
        rptr_q <= rptr_q + 2'd1;
      end
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      flush_q <= 1'b0;
    end else begin
      flush_q <= flush_d;
    end
  end

  // busy_o low implies S_IDLE, so an SPR load can never collide
  // with the ack-driven increment below.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      req_q   <= 1'b0;
      dat_q   <= 8'h00;
      addr_q  <= RST_ADDR;
    end else begin
      if (spr_we & ~busy_o) begin
        addr_q <= spr_dat_i;
      end
      unique case (state_q)
        S_IDLE: begin
          if (pop) begin
            state_q <= S_WRITE;
            req_q   <= 1'b1;
            dat_q   <= head;
          end
        end
`ifdef OR1200_VLX_STUFF_EN
        S_WRITE,
        S_STUFF: begin
`else
        S_WRITE: begin
`endif
          if (ack_i) begin
            addr_q <= addr_q + 32'd1;
            if (stuff_go) begin
`ifdef OR1200_VLX_STUFF_EN
              state_q <= S_STUFF;
`endif
              dat_q   <= 8'h00;
            end else if (pop) begin
              state_q <= S_WRITE;
              dat_q   <= head;
            end else begin
              state_q <= S_IDLE;
              req_q   <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

endmodule
